// File: rtl/instr_fetch.sv
// nRISC fetch/issue sequencer: owns the PC, fetches 8-bit instructions over req/ack, selects next PC.
// Optional retired-instruction counter (output retired) when RETIRE_CNT_EN is defined.
module instr_fetch #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imemReq,
  output logic [PC_W-1:0] imemAddr,
  input  logic [7:0]      imemData,
  input  logic            imemAck,
  output logic            instrValid,
  output logic [2:0]      opCode,
  output logic            funct,
  output logic [7:0]      instr,
  output logic [PC_W-1:0] pc,
  input  logic            PcWrite,
  input  logic            Jump,
  input  logic            Bnez,
  input  logic            regNonZero,
  input  logic [PC_W-1:0] jrTarget,
`ifdef RETIRE_CNT_EN
  output logic [15:0]     retired,
`endif
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [PC_W-1:0] ONE = PC_W'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [7:0]      r_ir;
  logic            r_req;
  logic            w_next_req;
  logic            w_accept;
  logic [PC_W-1:0] w_offset;

  // An ack only counts while our own request is outstanding; this drops stale acks after reset.
  assign w_accept = (r_state == S_FETCH) && r_req && imemAck;
  assign w_offset = {{(PC_W-4){r_ir[4]}}, r_ir[4:1]};

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_req   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next_req = ~w_accept;
        if (w_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (!PcWrite) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_FETCH;
          w_next_req   = 1'b1;
          if (Jump)                   w_next_pc = jrTarget;
          else if (Bnez && regNonZero) w_next_pc = r_pc + ONE + w_offset;
          else                        w_next_pc = r_pc + ONE;
        end
      end
      default: w_next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_req   <= w_next_req;
      if (w_accept) r_ir <= imemData;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [15:0] r_retired;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= '0;
    end else if (r_state == S_EXEC && PcWrite) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired = r_retired;
`endif

  assign imemReq    = r_req;
  assign imemAddr   = r_pc;
  assign instrValid = (r_state == S_ISSUE);
  assign opCode     = r_ir[7:5];
  assign funct      = r_ir[0];
  assign instr      = r_ir;
  assign pc         = r_pc;
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver pushes expected fetch addresses, monitor checks each request/issue.
module tb_instr_fetch;
  localparam int unsigned PC_W = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            imemReq;
  logic [PC_W-1:0] imemAddr;
  logic [7:0]      imemData;
  logic            imemAck;
  logic            instrValid;
  logic [2:0]      opCode;
  logic            funct;
  logic [7:0]      instr;
  logic [PC_W-1:0] pc;
  logic            PcWrite = 1'b1;
  logic            Jump = 1'b0;
  logic            Bnez = 1'b0;
  logic            regNonZero = 1'b0;
  logic [PC_W-1:0] jrTarget = '0;
  logic            halted;
`ifdef RETIRE_CNT_EN
  logic [15:0]     retired;
`endif

  instr_fetch #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .imemAck    (imemAck),
    .instrValid (instrValid),
    .opCode     (opCode),
    .funct      (funct),
    .instr      (instr),
    .pc         (pc),
    .PcWrite    (PcWrite),
    .Jump       (Jump),
    .Bnez       (Bnez),
    .regNonZero (regNonZero),
    .jrTarget   (jrTarget),
`ifdef RETIRE_CNT_EN
    .retired    (retired),
`endif
    .halted     (halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory model
  logic [7:0]  imem [256];
  logic [7:0]  exp_q [$];
  int          lat = 1;
  int          cnt = 0;
  bit          pending = 0;
  logic        mem_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  mem_addr = 8'h00;

  assign imemAck  = mem_ack | stray_ack;
  assign imemData = stray_ack ? 8'hFF : mem_data;

  initial forever begin
    @(posedge clock);
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (pending) begin
      cnt--;
      if (cnt <= 0) begin
        mem_ack  = 1'b1;
        mem_data = imem[mem_addr];
        pending  = 0;
      end
    end else if (imemReq) begin
      pending  = 1;
      cnt      = lat;
      mem_addr = imemAddr;
    end
  end

  // Monitor
  logic       prev_req = 1'b0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] exp_instr;

  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      prev_req = 1'b0;
    end else begin
      if (imemReq && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got addr %0h expected no request", imemAddr);
        end else begin
          chk("fetch_addr", imemAddr, exp_q.pop_front());
        end
        last_addr = imemAddr;
      end
      if (instrValid) begin
        exp_instr = imem[last_addr];
        chk("issue_instr", instr, exp_instr);
        chk("issue_pc", pc, last_addr);
        chk("issue_opcode", opCode, exp_instr[7:5]);
        chk("issue_funct", funct, exp_instr[0]);
      end
      prev_req = imemReq;
    end
  end

  int t_valid = 0;

  task automatic wait_valid();
    int n = 0;
    @(negedge clock);
    while (!instrValid && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!instrValid) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no instrValid expected pulse within 60 cycles");
    end
    t_valid = cyc;
  endtask

  task automatic run_vec(input logic pw, input logic j, input logic b, input logic nz,
                         input logic [7:0] jr, input logic [7:0] nxt);
    wait_valid();
    PcWrite    = pw;
    Jump       = j;
    Bnez       = b;
    regNonZero = nz;
    jrTarget   = jr;
    if (pw) exp_q.push_back(nxt);
  endtask

  task automatic check_reset_state();
    chk("rst_req", imemReq, 0);
    chk("rst_valid", instrValid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", instr, 0);
  endtask

  task automatic halt_check(input logic [7:0] hpc, input logic [7:0] hir);
    int reqs = 0;
    repeat (2) @(negedge clock);
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, hpc);
    chk("halt_ir", instr, hir);
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (imemReq || instrValid) reqs++;
      if (i == 5) stray_ack = 1'b1;
      if (i == 6) stray_ack = 1'b0;
    end
    chk("halt_no_req", reqs, 0);
    chk("halt_ir_after_ack", instr, hir);
    chk("halt_sticky", halted, 1);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h20;
    imem[8'h03] = 8'h8A;
    imem[8'h09] = 8'h8A;
    imem[8'h40] = 8'h9E;
    imem[8'h41] = 8'h90;

    repeat (3) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clock);
    #1;
    chk("req_first_cycle", imemReq, 1);
    chk("addr_first_cycle", imemAddr, 0);

    // Phase 1: sequential, branches, jump priority, wrap, halt
    run_vec(1, 0, 0, 0, 8'h00, 8'h01);
    t0 = t_valid;
    run_vec(1, 0, 0, 0, 8'h00, 8'h02);
    chk("issue_period", t_valid - t0, 4);
    t0 = t_valid;
    run_vec(1, 0, 0, 0, 8'h00, 8'h03);
    chk("issue_period2", t_valid - t0, 4);
    run_vec(1, 0, 1, 1, 8'h00, 8'h09);   // 8A at 3, taken +5
    run_vec(1, 0, 1, 0, 8'h00, 8'h0A);   // 8A at 9, not taken
    run_vec(1, 1, 1, 1, 8'h40, 8'h40);   // jump beats bnez
    run_vec(1, 0, 1, 1, 8'h00, 8'h40);   // 9E at 40, -1
    run_vec(1, 0, 1, 0, 8'h00, 8'h41);
    run_vec(1, 0, 1, 1, 8'h00, 8'h3A);   // 90 at 41, -8
    run_vec(1, 1, 0, 0, 8'hFF, 8'hFF);
    run_vec(1, 0, 0, 0, 8'h00, 8'h00);   // FF + 1 wraps
    run_vec(0, 0, 0, 0, 8'h00, 8'h00);   // halt at 0
    repeat (2) @(negedge clock);
    chk("p1_halted", halted, 1);
    chk("p1_halt_pc", pc, 0);
`ifdef RETIRE_CNT_EN
    chk("p1_retired", retired, 11);
`endif

    // Phase 2: reset out of halt, negative wrap, reset mid-fetch
    imem[8'h02] = 8'h90;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(8'h00);
    run_vec(1, 1, 0, 0, 8'h02, 8'h02);
    run_vec(1, 0, 1, 1, 8'h00, 8'hFB);   // 90 at 2 -> FB
    lat = 6;
    begin
      int n = 0;
      while (!imemReq && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("fb_req_seen", imemReq, 1);
    end
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1 chk("req_async_drop", imemReq, 0);
    repeat (8) @(negedge clock);
    lat = 1;
    exp_q.push_back(8'h00);
    reset_n = 1'b1;
    stray_ack = 1'b1;
    @(posedge clock);
    #1 stray_ack = 1'b0;
    chk("ir_after_stray_ack", instr, 0);
    chk("req_after_release", imemReq, 1);

    // Phase 3: three instructions then halt
    run_vec(1, 0, 0, 0, 8'h00, 8'h01);
    run_vec(1, 0, 0, 0, 8'h00, 8'h02);
    run_vec(1, 0, 1, 0, 8'h00, 8'h03);   // 90 at 2, not taken
    run_vec(0, 1, 1, 1, 8'h55, 8'h00);   // halt wins over all
    halt_check(8'h03, 8'h8A);
`ifdef RETIRE_CNT_EN
    chk("p3_retired", retired, 3);
`endif
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
